compare_arbiter: RTL and testbench
==================================

COMPARE_ARBITER -- requirements
Module: compare_arbiter

Interface
REQ-001 The block SHALL have parameter: WIDTH, 8, operand width in bits of the shared comparator.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port: req  input  4  per-requester compare request, bit i = requester i.
REQ-005 The block SHALL have port: a_in  input  4*WIDTH  operand A per requester, slice i = bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port: b_in  input  4*WIDTH  operand B per requester, same slicing as a_in.
REQ-007 The block SHALL have port: gnt  output  4  one-hot grant to the requester whose operands are latched.
REQ-008 The block SHALL have port: done  output  1  one-cycle pulse; result outputs valid.
REQ-009 The block SHALL have port: res_id  output  2  requester index owning the current result.
REQ-010 The block SHALL have port: less, equal, greater  output  1 each  unsigned A<B, A==B, A>B of the served pair.
REQ-011 The block SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL contain one WIDTH-bit unsigned comparator shared by all requesters.
REQ-013 The FSM SHALL have states IDLE, LATCH, RESULT; IDLE->LATCH when any req bit is high, LATCH->RESULT unconditionally, RESULT->IDLE unconditionally.
REQ-014 In IDLE with req!=0, the winner SHALL be chosen; on the next edge its a/b slices SHALL be latched into internal operand registers, gnt SHALL go one-hot for the winner, and the state SHALL become LATCH.
REQ-015 In LATCH, the comparator SHALL evaluate the latched operands; on the next edge less/equal/greater SHALL be registered, done SHALL be set, res_id SHALL be set to the winner, and gnt SHALL clear.
REQ-016 done SHALL be high for exactly the one cycle in RESULT; less/equal/greater/res_id SHALL hold their values until the next done.
REQ-017 Latency SHALL be fixed: req sampled at edge n -> gnt high in cycle n+1 -> done high in cycle n+2; back-to-back service SHALL restart from IDLE, giving one result per 3 cycles.
REQ-018 Exactly one of less/equal/greater SHALL be 1 whenever done is high.
REQ-019 Requesters SHALL hold req and operands until gnt; operand changes after the latch edge SHALL NOT affect the result.
REQ-020 req bits deasserted before selection SHALL be ignored; req changes during LATCH or RESULT SHALL NOT affect the request in service.
REQ-021 A requester still holding req after its done SHALL be treated as a new request.

Reset
REQ-022 When reset is high at a clock edge, state SHALL become IDLE, and gnt=0, done=0, busy=0, res_id=0, less=0, equal=0, greater=0, with the round-robin pointer cleared to 0.
REQ-023 Reset in LATCH or RESULT SHALL abort the compare; no done SHALL be produced for the aborted request.

Configuration
REQ-024 Macro CMP_ROUND_ROBIN_EN defined: winner SHALL be the first asserted req bit searching from pointer p upward with wrap 3->0; after each done, p SHALL become (res_id+1) mod 4.
REQ-025 CMP_ROUND_ROBIN_EN undefined: winner SHALL be the lowest-index asserted req bit (fixed priority, 0 highest); no pointer state SHALL exist.

Verification
REQ-026 Single request: req=0001, a0=0x0B, b0=0x07 -> gnt=0001 one cycle later, then done with res_id=0, greater=1.
REQ-027 Equal/less operands: req=0100, a2=0x0A, b2=0x0A -> equal=1, res_id=2; then a2=0x00, b2=0xFF -> less=1.
REQ-028 All requesting, held, CMP_ROUND_ROBIN_EN defined: req=1111 -> res_id sequence 0,1,2,3,0, with a done every 3 cycles; undefined -> res_id 0,0,0.
REQ-029 Operand change after grant: a1=0xAB, b1=0xAA latched, then a1 set to 0x00 in LATCH -> greater=1 still reported.
REQ-030 Reset mid-operation: reset asserted in LATCH -> next cycle all outputs 0, no done pulse; a subsequent req=1000 is served normally with res_id=3.

Source files
------------

// File: rtl/compare_arbiter.sv
// Four-requester arbiter sharing one unsigned WIDTH-bit comparator, one result per three cycles.
// Define CMP_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (requester 0 highest).
module compare_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_in,
  input  logic [4*WIDTH-1:0]   b_in,
  output logic [3:0]           gnt,
  output logic                 done,
  output logic [1:0]           res_id,
  output logic                 less,
  output logic                 equal,
  output logic                 greater,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [1:0]       win_q;
  logic [3:0]       gnt_q;
  logic             done_q;
  logic [1:0]       res_id_q;
  logic             less_q;
  logic             equal_q;
  logic             greater_q;
  logic             busy_q;

  logic [1:0]       win_d;
  logic             lt_d;
  logic             eq_d;
  logic             gt_d;

`ifdef CMP_ROUND_ROBIN_EN
  logic [1:0]       ptr_q;

  // First asserted request at or above the pointer, wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Winner selection from the live request vector.
  always_comb begin
    win_d = rr_pick(req, ptr_q);
  end
`else
  // Lowest asserted index wins.
  function automatic logic [1:0] fp_pick(input logic [3:0] r);
    logic [1:0] pick;
    pick = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r[k]) begin
        pick = 2'(k);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Winner selection from the live request vector.
  always_comb begin
    win_d = fp_pick(req);
  end
`endif

  // Shared comparator on the latched operands only.
  always_comb begin
    lt_d = (op_a_q <  op_b_q);
    eq_d = (op_a_q == op_b_q);
    gt_d = (op_a_q >  op_b_q);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      win_q     <= 2'd0;
      gnt_q     <= 4'd0;
      done_q    <= 1'b0;
      res_id_q  <= 2'd0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef CMP_ROUND_ROBIN_EN
      ptr_q     <= 2'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (|req) begin
            op_a_q  <= a_in[win_d*WIDTH +: WIDTH];
            op_b_q  <= b_in[win_d*WIDTH +: WIDTH];
            win_q   <= win_d;
            gnt_q   <= 4'b0001 << win_d;
            busy_q  <= 1'b1;
            state_q <= LATCH;
          end else begin
            gnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        LATCH: begin
          less_q    <= lt_d;
          equal_q   <= eq_d;
          greater_q <= gt_d;
          res_id_q  <= win_q;
          done_q    <= 1'b1;
          gnt_q     <= 4'd0;
          busy_q    <= 1'b1;
          state_q   <= RESULT;
`ifdef CMP_ROUND_ROBIN_EN
          ptr_q     <= win_q + 2'd1;
`endif
        end
        RESULT: begin
          done_q  <= 1'b0;
          gnt_q   <= 4'd0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          gnt_q   <= 4'd0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign res_id  = res_id_q;
  assign less    = less_q;
  assign equal   = equal_q;
  assign greater = greater_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// Self-checking bench for compare_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_compare_arbiter;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     req;
  logic [4*W-1:0] a_in;
  logic [4*W-1:0] b_in;
  logic [3:0]     gnt;
  logic           done;
  logic [1:0]     res_id;
  logic           less;
  logic           equal;
  logic           greater;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one transaction in flight, phase 0 idle, 1 granted, 2 result.
  int         m_phase = 0;
  int         m_ptr   = 0;
  int         m_win   = 0;
  logic [W-1:0] m_a, m_b;
  logic [3:0] m_gnt = 4'd0;
  logic       m_done = 1'b0;
  logic [1:0] m_res = 2'd0;
  logic       m_lt = 1'b0, m_eq = 1'b0, m_gt = 1'b0;

  int done_ids[$];
  int done_cyc[$];

  compare_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .res_id(res_id), .less(less), .equal(equal),
    .greater(greater), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_gnt = 4'd0; m_done = 1'b0; m_res = 2'd0;
      m_lt = 1'b0; m_eq = 1'b0; m_gt = 1'b0;
    end else if (m_phase == 0) begin
      m_done = 1'b0;
      if (req != 4'd0) begin
        m_win   = pick(req, m_ptr);
        m_a     = a_in[m_win*W +: W];
        m_b     = b_in[m_win*W +: W];
        m_gnt   = 4'(1 << m_win);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_lt = (m_a < m_b); m_eq = (m_a == m_b); m_gt = (m_a > m_b);
      m_done = 1'b1; m_res = m_win[1:0]; m_gnt = 4'd0; m_phase = 2;
`ifdef CMP_ROUND_ROBIN_EN
      m_ptr = (m_win + 1) % 4;
`endif
    end else begin
      m_done = 1'b0; m_phase = 0;
    end
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("done", 32'(done), 32'(m_done));
    chk("res_id", 32'(res_id), 32'(m_res));
    chk("less", 32'(less), 32'(m_lt));
    chk("equal", 32'(equal), 32'(m_eq));
    chk("greater", 32'(greater), 32'(m_gt));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    if (done === 1'b1) begin
      chk("onehot_result", 32'($countones({less, equal, greater})), 32'd1);
      done_ids.push_back(int'(res_id));
      done_cyc.push_back(cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  initial begin
    reset = 1'b1; req = 4'd0; a_in = '0; b_in = '0;
    step(); step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Single request, A > B
    set_ops(0, 8'h0B, 8'h07); req = 4'b0001;
    step();
    chk("r026_gnt", 32'(gnt), 32'h1);
    req = 4'd0;
    step();
    chk("r026_done", 32'(done), 32'd1);
    chk("r026_gt", 32'(greater), 32'd1);
    chk("r026_id", 32'(res_id), 32'd0);
    step();

    // Equal then less on requester 2
    set_ops(2, 8'h0A, 8'h0A); req = 4'b0100;
    step(); req = 4'd0; step();
    chk("r027_eq", 32'(equal), 32'd1);
    chk("r027_id", 32'(res_id), 32'd2);
    step();
    set_ops(2, 8'h00, 8'hFF); req = 4'b0100;
    step(); req = 4'd0; step();
    chk("r027_lt", 32'(less), 32'd1);
    step();

    // Operand change after the latch edge
    set_ops(1, 8'hAB, 8'hAA); req = 4'b0010;
    step();
    set_ops(1, 8'h00, 8'hAA); req = 4'd0;
    step();
    chk("r029_gt", 32'(greater), 32'd1);
    chk("r029_id", 32'(res_id), 32'd1);
    step();

    // Reset while in LATCH aborts the compare
    set_ops(0, 8'h01, 8'h02); req = 4'b0001;
    step();
    reset = 1'b1; req = 4'd0;
    step();
    chk("r030_done", 32'(done), 32'd0);
    chk("r030_gt", 32'(greater), 32'd0);
    reset = 1'b0;
    step();
    chk("r030_nodone", 32'(done), 32'd0);
    set_ops(3, 8'h05, 8'h09); req = 4'b1000;
    step(); req = 4'd0; step();
    chk("r030_id", 32'(res_id), 32'd3);
    chk("r030_lt", 32'(less), 32'd1);
    step();

    // All requesters held
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i * 16), 8'h20);
    done_ids.delete(); done_cyc.delete();
    req = 4'b1111;
    repeat (15) step();
    req = 4'd0;
    step(); step();
    chk("r028_count", 32'(done_ids.size()), 32'd5);
    if (done_ids.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
`ifdef CMP_ROUND_ROBIN_EN
        chk("r028_rr_id", 32'(done_ids[i]), 32'(i % 4));
`else
        chk("r028_fp_id", 32'(done_ids[i]), 32'd0);
`endif
        if (i > 0) chk("r028_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd3);
      end
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      req   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      a_in  = $urandom;
      b_in  = ($urandom_range(0, 3) == 0) ? a_in : $urandom;
      step();
    end
    reset = 1'b0; req = 4'd0;
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
